// File: rtl/piccolo80_enc_ctrl.sv
// Piccolo-80 encryption sequencer: whitening, per-round key/constant selection,
// one round per clock through an external combinational round core.
module piccolo80_enc_ctrl #(
  parameter int ROUNDS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] plaintext,
  output logic        busy,
  output logic        done,
  output logic [63:0] ciphertext,
  output logic [63:0] rc_state,
  output logic [31:0] rc_rk0,
  output logic [4:0]  rc_round,
  input  logic [63:0] rc_result
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  fsm_t        fsm;
  logic [79:0] key_q;
  logic [4:0]  ctr;
  logic [2:0]  phase;
  logic [2:0]  phase_nxt;

  // Key word k0 sits in the most significant 16 bits of the key bus.
  function automatic logic [31:0] round_key(input logic [79:0] k, input logic [2:0] ph);
    logic [31:0] rk;
    case (ph)
      3'd0, 3'd2: rk = k[47:16];
      3'd1, 3'd4: rk = k[79:48];
      default:    rk = {k[15:0], k[15:0]};
    endcase
    return rk;
  endfunction

  function automatic logic [63:0] pre_whiten(input logic [63:0] pt, input logic [79:0] k);
    logic [15:0] wk0;
    logic [15:0] wk1;
    wk0 = {k[79:72], k[55:48]};
    wk1 = {k[63:56], k[71:64]};
    return {pt[63:48] ^ wk0, pt[47:32], pt[31:16] ^ wk1, pt[15:0]};
  endfunction

  function automatic logic [63:0] post_whiten(input logic [63:0] t, input logic [79:0] k);
    logic [15:0] wk2;
    logic [15:0] wk3;
    wk2 = {k[15:8], k[23:16]};
    wk3 = {k[31:24], k[7:0]};
    return {t[63:48] ^ wk2, t[47:32], t[31:16] ^ wk3, t[15:0]};
  endfunction

  // The core always applies RP; the final round must not have it.
  function automatic logic [63:0] inv_rp(input logic [63:0] r);
    return {r[15:8], r[39:32], r[63:56], r[23:16], r[47:40], r[7:0], r[31:24], r[55:48]};
  endfunction

  assign phase_nxt = (phase == 3'd4) ? 3'd0 : phase + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
      rc_state   <= '0;
      rc_rk0     <= '0;
      rc_round   <= 5'd1;
      ctr        <= '0;
      phase      <= '0;
      key_q      <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            rc_state <= pre_whiten(plaintext, key);
            rc_rk0   <= round_key(key, 3'd0);
            rc_round <= 5'd1;
            ctr      <= '0;
            phase    <= '0;
            busy     <= 1'b1;
            fsm      <= RUN;
          end
        end
        RUN: begin
          if (ctr == LAST) begin
            ciphertext <= post_whiten(inv_rp(rc_result), key_q);
            done       <= 1'b1;
            busy       <= 1'b0;
            ctr        <= '0;
            phase      <= '0;
            rc_round   <= 5'd1;
            fsm        <= IDLE;
          end else begin
            rc_state <= rc_result;
            ctr      <= ctr + 5'd1;
            phase    <= phase_nxt;
            rc_round <= ctr + 5'd2;
            rc_rk0   <= round_key(key_q, phase_nxt);
          end
        end
      endcase
    end
  end

endmodule
